// File: rtl/bht_sram_ctrl.sv
// Generic synchronous FIFO, head visible combinationally on dout_o, one-cycle push-to-visible latency.
// Push while full is legal only with a same-cycle pop; clr_i empties it and overrides push/pop.
module fifo_sync #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic [DW-1:0] din_i,
  input  logic          pop_i,
  output logic [DW-1:0] dout_o,
  output logic          empty_o,
  output logic          full_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;

  always_ff @(posedge clk_i) begin
    if (push_i && !clr_i) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
endmodule

// Single-port BHT sequencer: lookups read in the grant cycle (pred one cycle later); updates are
// queued and read-modify-written (read, capture, write); a full queue drops updates with a pulse.
module bht_sram_ctrl #(
  parameter int unsigned NR_ROWS         = 512,
  parameter int unsigned INSTR_PER_FETCH = 2,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned STARVE_LIMIT    = 8,
  parameter int unsigned ROW_W           = $clog2(NR_ROWS),
  parameter int unsigned COL_W           = (INSTR_PER_FETCH > 1) ? $clog2(INSTR_PER_FETCH) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           flush_i,
  input  logic                           debug_mode_i,
  input  logic                           lookup_valid_i,
  input  logic [ROW_W-1:0]               lookup_row_i,
  output logic                           pred_valid_o,
  output logic [INSTR_PER_FETCH*3-1:0]   pred_o,
  input  logic                           upd_valid_i,
  input  logic [ROW_W-1:0]               upd_row_i,
  input  logic [COL_W-1:0]               upd_col_i,
  input  logic                           upd_taken_i,
  output logic                           upd_drop_o,
  output logic                           init_busy_o,
  output logic                           mem_req_o,
  output logic                           mem_we_o,
  output logic [ROW_W-1:0]               mem_addr_o,
  output logic [INSTR_PER_FETCH*3-1:0]   mem_wdata_o,
  input  logic [INSTR_PER_FETCH*3-1:0]   mem_rdata_i
);
  localparam int unsigned ROW_DW = INSTR_PER_FETCH * 3;
  localparam int unsigned SC_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [ROW_DW-1:0] INIT_ROW = {INSTR_PER_FETCH{3'b010}};

  typedef enum logic [1:0] {INIT, IDLE, RDATA, WRITE} state_e;
  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             taken;
  } upd_t;

  state_e            state_q, state_d;
  logic [ROW_W-1:0]  walk_q, walk_d;
  logic [SC_W-1:0]   starve_q, starve_d;
  upd_t              rmw_q, rmw_d, fifo_in, fifo_head;
  logic [ROW_DW-1:0] rmw_dat_q, rmw_dat_d, rmw_new;
  logic              pred_valid_q, pred_blank_q, drop_q;
  logic              fifo_empty, fifo_full, fifo_push, fifo_pop;
  logic              upd_req, pending, upd_wins, lookup_grant;
  logic              req, we;
  logic [ROW_W-1:0]  addr;
  logic [ROW_DW-1:0] wdata;
  logic [1:0]        ctr;

  assign upd_req      = upd_valid_i && !debug_mode_i && !flush_i;
  assign pending      = ((state_q == IDLE) && !fifo_empty) || (state_q == WRITE);
  assign upd_wins     = pending && (!lookup_valid_i || (starve_q == SC_W'(STARVE_LIMIT)));
  assign fifo_pop     = !flush_i && (state_q == IDLE) && upd_wins;
  assign fifo_push    = upd_req && (!fifo_full || fifo_pop);
  assign lookup_grant = lookup_valid_i && !flush_i && (state_q != INIT) && !upd_wins;
  assign fifo_in      = {upd_row_i, upd_col_i, upd_taken_i};

  fifo_sync #(.DW($bits(upd_t)), .DEPTH(FIFO_DEPTH)) u_upd_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (flush_i),
    .push_i  (fifo_push),
    .din_i   (fifo_in),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // Saturating counter step applied to the captured row, entry rmw_q.col only.
  always_comb begin
    rmw_new = mem_rdata_i;
    ctr     = '0;
    for (int i = 0; i < INSTR_PER_FETCH; i++) begin
      if (COL_W'(i) == rmw_q.col) begin
        ctr = mem_rdata_i[3*i +: 2];
        if (rmw_q.taken) ctr = (ctr == 2'b11) ? ctr : ctr + 2'd1;
        else             ctr = (ctr == 2'b00) ? ctr : ctr - 2'd1;
        rmw_new[3*i +: 3] = {1'b1, ctr};
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    walk_d    = walk_q;
    rmw_d     = rmw_q;
    rmw_dat_d = rmw_dat_q;
    starve_d  = (pending && !upd_wins) ? starve_q + SC_W'(1) : '0;
    req       = 1'b0;
    we        = 1'b0;
    addr      = lookup_row_i;
    wdata     = '0;
    if (flush_i) begin
      state_d  = INIT;
      walk_d   = '0;
      starve_d = '0;
    end else begin
      case (state_q)
        INIT: begin
          req    = 1'b1;
          we     = 1'b1;
          addr   = walk_q;
          wdata  = INIT_ROW;
          walk_d = walk_q + ROW_W'(1);
          if (walk_q == ROW_W'(NR_ROWS - 1)) state_d = IDLE;
        end
        IDLE: begin
          if (upd_wins) begin
            req     = 1'b1;
            addr    = fifo_head.row;
            rmw_d   = fifo_head;
            state_d = RDATA;
          end
        end
        RDATA: begin
          rmw_dat_d = rmw_new;
          state_d   = WRITE;
        end
        WRITE: begin
          if (upd_wins) begin
            req     = 1'b1;
            we      = 1'b1;
            addr    = rmw_q.row;
            wdata   = rmw_dat_q;
            state_d = IDLE;
          end
        end
        default: state_d = INIT;
      endcase
      if (lookup_grant) begin
        req  = 1'b1;
        addr = lookup_row_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= INIT;
      walk_q       <= '0;
      starve_q     <= '0;
      rmw_q        <= '0;
      rmw_dat_q    <= '0;
      pred_valid_q <= 1'b0;
      pred_blank_q <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      walk_q       <= walk_d;
      starve_q     <= starve_d;
      rmw_q        <= rmw_d;
      rmw_dat_q    <= rmw_dat_d;
      pred_valid_q <= lookup_valid_i;
      pred_blank_q <= !lookup_grant;
      drop_q       <= upd_req && fifo_full && !fifo_pop;
    end
  end

  // The reset state is INIT, so the walk write is held off until reset is released.
  assign mem_req_o    = req && rst_ni;
  assign mem_we_o     = we && rst_ni;
  assign mem_addr_o   = addr;
  assign mem_wdata_o  = rst_ni ? wdata : '0;
  assign pred_valid_o = pred_valid_q;
  assign pred_o       = (pred_valid_q && !pred_blank_q) ? mem_rdata_i : '0;
  assign upd_drop_o   = drop_q;
  assign init_busy_o  = (state_q == INIT);
endmodule

// File: tb/tb_bht_sram_ctrl.sv
// Bench for bht_sram_ctrl: SRAM model plus an abstract table model of counter semantics.
module tb_bht_sram_ctrl;
  localparam int NR = 8, IPF = 2, RW = 3, CW = 1, DW = 6;
  localparam logic [DW-1:0] INIT_ROW = 6'b010010;

  logic          clk_i = 1'b0, rst_ni = 1'b0, flush_i = 1'b0, debug_mode_i = 1'b0;
  logic          lookup_valid_i = 1'b0, upd_valid_i = 1'b0, upd_taken_i = 1'b0;
  logic [RW-1:0] lookup_row_i = '0, upd_row_i = '0;
  logic [CW-1:0] upd_col_i = '0;
  logic          pred_valid_o, upd_drop_o, init_busy_o, mem_req_o, mem_we_o;
  logic [DW-1:0] pred_o, mem_wdata_o, mem_rdata_i = '0;
  logic [RW-1:0] mem_addr_o;

  logic [DW-1:0] sram [NR];
  int total = 0, bad = 0, wr_cnt = 0, drop_cnt = 0;
  int m_ctr [NR][IPF];
  bit m_val [NR][IPF];

  bht_sram_ctrl #(.NR_ROWS(NR), .INSTR_PER_FETCH(IPF), .FIFO_DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .debug_mode_i(debug_mode_i),
    .lookup_valid_i(lookup_valid_i), .lookup_row_i(lookup_row_i),
    .pred_valid_o(pred_valid_o), .pred_o(pred_o),
    .upd_valid_i(upd_valid_i), .upd_row_i(upd_row_i), .upd_col_i(upd_col_i),
    .upd_taken_i(upd_taken_i), .upd_drop_o(upd_drop_o), .init_busy_o(init_busy_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (mem_req_o) begin
      if (mem_we_o) sram[mem_addr_o] <= mem_wdata_o;
      else          mem_rdata_i <= sram[mem_addr_o];
    end
    if (rst_ni && mem_req_o && mem_we_o) wr_cnt <= wr_cnt + 1;
    if (upd_drop_o) drop_cnt <= drop_cnt + 1;
  end

  function automatic void m_init();
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < IPF; c++) begin
        m_ctr[r][c] = 2;
        m_val[r][c] = 1'b0;
      end
  endfunction

  function automatic void m_upd(int r, int c, bit t);
    m_val[r][c] = 1'b1;
    if (t) m_ctr[r][c] = (m_ctr[r][c] < 3) ? m_ctr[r][c] + 1 : 3;
    else   m_ctr[r][c] = (m_ctr[r][c] > 0) ? m_ctr[r][c] - 1 : 0;
  endfunction

  function automatic logic [DW-1:0] m_row(int r);
    logic [DW-1:0] v = '0;
    for (int c = 0; c < IPF; c++) v[3*c +: 3] = {m_val[r][c], 2'(m_ctr[r][c])};
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic send_upd(input int r, input int c, input bit t);
    upd_valid_i = 1'b1; upd_row_i = RW'(r); upd_col_i = CW'(c); upd_taken_i = t;
    m_upd(r, c, t);
    tick();
    upd_valid_i = 1'b0;
  endtask

  task automatic lookup_chk(input string tag, input int r);
    lookup_valid_i = 1'b1; lookup_row_i = RW'(r);
    tick();
    lookup_valid_i = 1'b0;
    chk({tag, "_vld"}, 32'(pred_valid_o), 32'd1);
    chk(tag, 32'(pred_o), 32'(m_row(r)));
  endtask

  task automatic check_table(input string tag);
    for (int r = 0; r < NR; r++) chk(tag, 32'(sram[r]), 32'(m_row(r)));
  endtask

  // Checks n walk writes starting at row 0; a lookup mid-walk must come back blank.
  task automatic walk_chk(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      #1;
      chk(tag, 32'({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o}), 32'({2'b11, 3'(k), INIT_ROW}));
      chk({tag, "_busy"}, 32'(init_busy_o), 32'd1);
      if (k == 3) begin
        chk({tag, "_lk_vld"}, 32'(pred_valid_o), 32'd1);
        chk({tag, "_lk_dat"}, 32'(pred_o), 32'd0);
      end
      lookup_valid_i = (k == 2); lookup_row_i = 3'd5;
      tick();
    end
    lookup_valid_i = 1'b0;
  endtask

  initial begin
    int d0, w0, n, rnd_row, rnd_col;
    bit lk_prev, rnd_tk;
    int b_row [6] = '{0, 1, 2, 4, 5, 6};
    bit b_tk [6];
    int b_col [6];

    m_init();
    repeat (3) tick();
    chk("rst_busy", 32'(init_busy_o), 32'd1);
    chk("rst_pvld", 32'(pred_valid_o), 32'd0);
    chk("rst_pred", 32'(pred_o), 32'd0);
    chk("rst_drop", 32'(upd_drop_o), 32'd0);
    chk("rst_req", 32'(mem_req_o), 32'd0);
    chk("rst_we", 32'(mem_we_o), 32'd0);
    rst_ni = 1'b1;
    walk_chk("init_walk", NR);
    #1;
    chk("init_done", 32'(init_busy_o), 32'd0);
    chk("idle_noreq", 32'(mem_req_o), 32'd0);
    check_table("init_tab");

    // Uncontested RMW timing, then saturation on the same entry.
    tick();
    send_upd(3, 1, 1'b1);
    #1; chk("rmw_rd", 32'({mem_req_o, mem_we_o, mem_addr_o}), 32'({2'b10, 3'd3}));
    tick(); #1; chk("rmw_cap", 32'(mem_req_o), 32'd0);
    tick(); #1;
    chk("rmw_wr", 32'({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o}), 32'({2'b11, 3'd3, m_row(3)}));
    tick();
    send_upd(3, 1, 1'b1);
    send_upd(3, 1, 1'b1);
    repeat (12) tick();
    lookup_chk("row3", 3);
    chk("row3_c1", 32'(pred_o[5:3]), 32'd7);

    // Overflow burst under continuous lookups: starvation limit and drops.
    for (int i = 0; i < 6; i++) begin
      b_tk[i]  = 1'($urandom_range(0, 1));
      b_col[i] = int'($urandom_range(0, 1));
    end
    d0 = drop_cnt;
    for (int cyc = 0; cyc <= 10; cyc++) begin
      lookup_valid_i = (cyc < 10); lookup_row_i = 3'd7;
      upd_valid_i = (cyc < 6);
      if (cyc < 6) begin
        upd_row_i = RW'(b_row[cyc]); upd_col_i = CW'(b_col[cyc]); upd_taken_i = b_tk[cyc];
        if (cyc < 4) m_upd(b_row[cyc], b_col[cyc], b_tk[cyc]);
      end
      #1;
      if (cyc < 9) chk("starve_lk", 32'({mem_req_o, mem_we_o, mem_addr_o}), 32'({2'b10, 3'd7}));
      if (cyc == 9) chk("starve_upd", 32'({mem_req_o, mem_we_o, mem_addr_o}), 32'({2'b10, 3'd0}));
      if (cyc >= 1) chk("burst_pvld", 32'(pred_valid_o), 32'd1);
      if (cyc >= 1 && cyc <= 9) chk("burst_pdat", 32'(pred_o), 32'(m_row(7)));
      if (cyc == 10) chk("starve_blank", 32'(pred_o), 32'd0);
      chk("burst_drop", 32'(upd_drop_o), 32'((cyc == 5) || (cyc == 6)));
      tick();
    end
    lookup_valid_i = 1'b0; upd_valid_i = 1'b0;
    repeat (40) tick();
    chk("burst_ndrop", 32'(drop_cnt - d0), 32'd2);
    check_table("burst_tab");

    // Lookup collides with a pending write: lookup first, write next cycle.
    send_upd(5, 0, 1'($urandom_range(0, 1)));
    tick(); tick();
    lookup_valid_i = 1'b1; lookup_row_i = 3'd6;
    #1; chk("wrdef_lk", 32'({mem_req_o, mem_we_o, mem_addr_o}), 32'({2'b10, 3'd6}));
    tick();
    lookup_valid_i = 1'b0;
    #1;
    chk("wrdef_wr", 32'({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o}), 32'({2'b11, 3'd5, m_row(5)}));
    chk("wrdef_pvld", 32'(pred_valid_o), 32'd1);
    chk("wrdef_pdat", 32'(pred_o), 32'(m_row(6)));
    repeat (5) tick();

    // Flush while the RMW is capturing, then flush again mid-walk with an update offered.
    upd_valid_i = 1'b1; upd_row_i = 3'd2; upd_col_i = 1'b0; upd_taken_i = 1'b1;
    tick();
    upd_valid_i = 1'b0;
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    m_init();
    walk_chk("flush_walk", 4);
    flush_i = 1'b1; upd_valid_i = 1'b1;
    tick();
    flush_i = 1'b0; upd_valid_i = 1'b0;
    walk_chk("reflush_walk", NR);
    #1; chk("flush_done", 32'(init_busy_o), 32'd0);
    w0 = wr_cnt;
    repeat (10) tick();
    chk("flush_nowr", 32'(wr_cnt - w0), 32'd0);
    check_table("flush_tab");

    // Debug mode suppresses enqueue entirely.
    w0 = wr_cnt; d0 = drop_cnt;
    debug_mode_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      upd_valid_i = 1'b1; upd_row_i = RW'($urandom_range(0, NR - 1));
      upd_col_i = CW'($urandom_range(0, 1)); upd_taken_i = 1'($urandom_range(0, 1));
      tick();
    end
    upd_valid_i = 1'b0; debug_mode_i = 1'b0;
    repeat (10) tick();
    chk("dbg_nowr", 32'(wr_cnt - w0), 32'd0);
    chk("dbg_nodrop", 32'(drop_cnt - d0), 32'd0);

    // Random bursts that never overflow, with random lookups interleaved.
    d0 = drop_cnt;
    for (int it = 0; it < 25; it++) begin
      n = int'($urandom_range(1, 4));
      for (int j = 0; j < n + 4; j++) begin
        if (j < n) begin
          rnd_row = int'($urandom_range(0, NR - 1));
          rnd_col = int'($urandom_range(0, 1));
          rnd_tk  = 1'($urandom_range(0, 1));
          upd_valid_i = 1'b1; upd_row_i = RW'(rnd_row); upd_col_i = CW'(rnd_col); upd_taken_i = rnd_tk;
          m_upd(rnd_row, rnd_col, rnd_tk);
        end else begin
          upd_valid_i = 1'b0;
        end
        lk_prev = 1'($urandom_range(0, 1));
        lookup_valid_i = lk_prev; lookup_row_i = RW'($urandom_range(0, NR - 1));
        tick();
        chk("rnd_pvld", 32'(pred_valid_o), 32'(lk_prev));
      end
      upd_valid_i = 1'b0; lookup_valid_i = 1'b0;
      repeat (20) tick();
      check_table("rnd_tab");
      lookup_chk("rnd_lk", int'($urandom_range(0, NR - 1)));
    end
    chk("rnd_nodrop", 32'(drop_cnt - d0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
